// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory bus controller: access sizes,
// fault causes, FSM states and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLSIZE  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    // An access is aligned when the address low bits below its size are zero.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic r_mis;
        case (size)
            SZ_B:    r_mis = 1'b0;
            SZ_H:    r_mis = addr_lo[0];
            SZ_W:    r_mis = |addr_lo[1:0];
            default: r_mis = |addr_lo;
        endcase
        return r_mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data replicated across lanes, load data
// shifted down from its lane and sign/zero extended to XLEN.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int LANE_W = $clog2(XLEN/8)
) (
    input  logic [1:0]        i_wsize,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_wdata_rep,
    input  logic [1:0]        i_rsize,
    input  logic [LANE_W-1:0] i_rlane,
    input  logic              i_rsigned,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_rdata_ext
);

    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_keep;
    logic            w_sign;

    assign w_shift = i_rdata >> {i_rlane, 3'b000};

    // Store replication: the narrow datum appears on every lane of its width.
    always_comb begin
        case (i_wsize)
            SZ_B:    o_wdata_rep = {(XLEN/8){i_wdata[7:0]}};
            SZ_H:    o_wdata_rep = {(XLEN/16){i_wdata[15:0]}};
            SZ_W:    o_wdata_rep = {(XLEN/32){i_wdata[31:0]}};
            default: o_wdata_rep = i_wdata;
        endcase
    end

    // Load extension: keep the low bits of the access, fill the rest with the sign or zero.
    always_comb begin
        case (i_rsize)
            SZ_B: begin
                w_keep = ~({XLEN{1'b1}} << 7'd8);
                w_sign = i_rsigned & w_shift[7];
            end
            SZ_H: begin
                w_keep = ~({XLEN{1'b1}} << 7'd16);
                w_sign = i_rsigned & w_shift[15];
            end
            SZ_W: begin
                w_keep = ~({XLEN{1'b1}} << 7'd32);
                w_sign = i_rsigned & w_shift[31];
            end
            default: begin
                w_keep = {XLEN{1'b1}};
                w_sign = 1'b0;
            end
        endcase
        o_rdata_ext = (w_shift & w_keep) | ({XLEN{w_sign}} & ~w_keep);
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: accepts one MEM-stage access, runs the
// ACKD_n wait-state handshake, and reports completion or a fault.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic [XLEN-1:0] DAD,
    output logic [XLEN-1:0] ddt_o,
    output logic            ddt_oe,
    input  logic [XLEN-1:0] ddt_i,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    input  logic            ACKD_n
);

    localparam int         LANE_W = $clog2(XLEN/8);
    localparam logic [7:0] TO_L   = 8'(TIMEOUT);

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic            r_signed;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rdata;
    logic            r_fault;
    logic [1:0]      r_fault_cause;
    logic [XLEN-1:0] r_dad;
    logic [XLEN-1:0] r_ddt_o;
    logic            r_ddt_oe;
    logic            r_mreq;
    logic            r_write;
    logic [1:0]      r_size;

    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_rdata_ext;
    logic [7:0]      w_cnt_nxt;
    logic            w_illsize;
    logic            w_misalign;

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .i_wsize     (req_size),
        .i_wdata     (req_wdata),
        .o_wdata_rep (w_wdata_rep),
        .i_rsize     (r_size),
        .i_rlane     (r_dad[LANE_W-1:0]),
        .i_rsigned   (r_signed),
        .i_rdata     (ddt_i),
        .o_rdata_ext (w_rdata_ext)
    );

    assign w_illsize  = (req_size == SZ_D) && (XLEN == 32);
    assign w_misalign = misaligned(req_size, req_addr[2:0]);
    assign w_cnt_nxt  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    assign stall       = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_BUSY);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;
    assign DAD         = r_dad;
    assign ddt_o       = r_ddt_o;
    assign ddt_oe      = r_ddt_oe;
    assign MREQ        = r_mreq;
    assign WRITE       = r_write;
    assign SIZE        = r_size;

    // Access FSM, wait-state counter and registered bus/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_signed      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rdata       <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= FC_NONE;
            r_dad         <= '0;
            r_ddt_o       <= '0;
            r_ddt_oe      <= 1'b0;
            r_mreq        <= 1'b0;
            r_write       <= 1'b0;
            r_size        <= SZ_B;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rdata       <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= FC_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (!req_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_illsize) begin
                        r_state       <= ST_FAULT;
                        r_fault       <= 1'b1;
                        r_fault_cause <= FC_ILLSIZE;
                    end else if (w_misalign) begin
                        r_state       <= ST_FAULT;
                        r_fault       <= 1'b1;
                        r_fault_cause <= FC_MISALIGN;
                    end else begin
                        r_state  <= ST_BUSY;
                        r_cnt    <= 8'd0;
                        r_dad    <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_write  <= req_write;
                        r_ddt_oe <= req_write;
                        r_ddt_o  <= w_wdata_rep;
                        r_mreq   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!ACKD_n) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= r_write ? '0 : w_rdata_ext;
                        r_mreq      <= 1'b0;
                        r_ddt_oe    <= 1'b0;
                        r_write     <= 1'b0;
                    end else if (w_cnt_nxt == TO_L) begin
                        r_cnt         <= w_cnt_nxt;
                        r_state       <= ST_FAULT;
                        r_fault       <= 1'b1;
                        r_fault_cause <= FC_TIMEOUT;
                        r_mreq        <= 1'b0;
                        r_ddt_oe      <= 1'b0;
                        r_write       <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares every rsp_valid/fault strobe.
module tb_dmem_bus_ctrl;

    localparam int XLEN = 32;

    typedef struct packed {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_write, req_signed;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            stall, rsp_valid, fault, ddt_oe, mreq, write_o, ackd_n;
    logic [XLEN-1:0] rsp_rdata, dad, ddt_o, ddt_i;
    logic [1:0]      fault_cause, size_o;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    dmem_bus_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .fault(fault), .fault_cause(fault_cause),
        .DAD(dad), .ddt_o(ddt_o), .ddt_oe(ddt_oe), .ddt_i(ddt_i),
        .MREQ(mreq), .WRITE(write_o), .SIZE(size_o), .ACKD_n(ackd_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid || fault) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {62'd0, rsp_valid, fault}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind", {62'd0, rsp_valid, fault}, {62'd0, ~e.is_fault, e.is_fault});
                if (e.is_fault) check("fault_cause", {62'd0, fault_cause}, {62'd0, e.cause});
                else            check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
            end
        end
    end

    // ack_at: BUSY cycle on which ACKD_n is driven low (0 = never).
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] bus_rd,
                          input int ack_at, input exp_t e,
                          input int exp_stall, input int exp_mreq, input logic [31:0] exp_ddt);
        int n_stall = 0;
        int n_mreq  = 0;
        bit done    = 1'b0;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                ackd_n = 1'b1;
            end else begin
                n_stall++;
                if (mreq) begin
                    n_mreq++;
                    if (n_mreq == 1) begin
                        check("DAD", {32'd0, dad}, {32'd0, addr});
                        check("SIZE", {62'd0, size_o}, {62'd0, sz});
                        check("WRITE", {63'd0, write_o}, {63'd0, wr});
                        check("ddt_oe", {63'd0, ddt_oe}, {63'd0, wr});
                        if (wr) check("ddt_o", {32'd0, ddt_o}, {32'd0, exp_ddt});
                    end
                end
                ackd_n = !(mreq && n_mreq == ack_at);
                ddt_i  = bus_rd;
            end
        end
        if (!done) check("cycle_budget", 64'd0, 64'd1);
        check("stall_cycles", 64'(n_stall), 64'(exp_stall));
        check("mreq_cycles", 64'(n_mreq), 64'(exp_mreq));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        ddt_i = 32'd0; ackd_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mreq", {63'd0, mreq}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_ddt_oe", {63'd0, ddt_oe}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_fault", {61'd0, fault, fault_cause}, 64'd0);
        check("rst_dad", {32'd0, dad}, 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // sw 0x100, two wait states
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 3,
               '{1'b0, 2'b00, 32'h0}, 4, 3, 32'hDEADBEEF);
        // lb / lbu 0x103, zero wait
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1,
               '{1'b0, 2'b00, 32'hFFFFFF80}, 2, 1, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1,
               '{1'b0, 2'b00, 32'h00000080}, 2, 1, 32'h0);
        // sh 0x102 replication
        access(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1,
               '{1'b0, 2'b00, 32'h0}, 2, 1, 32'hABCDABCD);
        // misaligned lw
        access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1,
               '{1'b1, 2'b01, 32'h0}, 1, 0, 32'h0);
        // timeout with TIMEOUT=4, then normal accesses
        access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 0,
               '{1'b1, 2'b10, 32'h0}, 5, 4, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h12345678, 1,
               '{1'b0, 2'b00, 32'h12345678}, 2, 1, 32'h0);
        access(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h80010000, 2,
               '{1'b0, 2'b00, 32'hFFFF8001}, 3, 2, 32'h0);
        access(1'b1, 2'b00, 1'b0, 32'h205, 32'h000000A5, 32'h0, 1,
               '{1'b0, 2'b00, 32'h0}, 2, 1, 32'hA5A5A5A5);
        // ld on XLEN=32
        access(1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 32'h0, 1,
               '{1'b1, 2'b11, 32'h0}, 1, 0, 32'h0);

        // reset during the second BUSY cycle
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300;
        @(posedge clk);
        @(posedge clk); #1;
        check("busy2_mreq", {63'd0, mreq}, 64'd1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_mreq", {63'd0, mreq}, 64'd0);
        check("rst_busy_stall", {63'd0, stall}, 64'd0);
        check("rst_busy_ddt_oe", {63'd0, ddt_oe}, 64'd0);
        rst = 1'b0;
        ackd_n = 1'b0;
        @(negedge clk);
        ackd_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_ack_rsp", {62'd0, rsp_valid, mreq}, 64'd0);
        end

        repeat (2) @(negedge clk);
        check("pending_rsp", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Parametrised data-memory bus controller between the EX/MEM pipeline register and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Successor to the fixed single-cycle MEM access. Adds:
  - ACKD_n wait-state handshake with pipeline stall generation;
  - XLEN-generic byte-lane alignment and sign/zero extension;
  - misaligned-access, illegal-size and bus-timeout fault reporting.

Parameters:
- XLEN, 32: data/address width; 32 or 64 only.
- TIMEOUT, 15: max BUSY cycles without ACKD_n before a timeout fault; 1..255.
- LANE_W, $clog2(XLEN/8): derived localparam, address bits selecting a byte lane.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- req_valid  in  1  MEM-stage load/store present; held stable until the stall drops
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- stall  out  1  freeze IF..MEM pipeline registers
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  XLEN  aligned, extended load data; valid with rsp_valid
- fault  out  1  one-cycle fault strobe
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal size
- DAD  out  XLEN  bus address
- ddt_o  out  XLEN  bus write data; top level drives the DDT tristate
- ddt_oe  out  1  DDT output enable
- ddt_i  in  XLEN  bus read data
- MREQ  out  1  bus request, active high
- WRITE  out  1  bus write, active high
- SIZE  out  2  bus access size, same encoding as req_size
- ACKD_n  in  1  bus acknowledge, active low

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all registered outputs 0. State IDLE, counter 0.
- All bus outputs (DAD, ddt_o, ddt_oe, MREQ, WRITE, SIZE) are registered.
- stall = (state==IDLE && req_valid) || state==BUSY. Combinational.
- State IDLE, with req_valid=1:
  - size==11 and XLEN==32 → FAULT, cause 11.
  - Otherwise addr not aligned to size → FAULT, cause 01. Alignment rule: half needs addr[0]==0; word needs addr[1:0]==0; dword needs addr[2:0]==0.
  - Otherwise latch addr, size, signed, write and lane-replicated wdata → BUSY.
  - No bus activity on any fault path.
- State BUSY:
  - MREQ=1; DAD, SIZE, WRITE held stable; ddt_oe=WRITE.
  - ACKD_n is sampled at each rising edge.
  - ACKD_n==0 → capture ddt_i (loads) → DONE. MREQ, ddt_oe, WRITE fall on the same edge.
  - Otherwise increment the counter. When the counter reaches TIMEOUT → FAULT, cause 10, MREQ dropped.
- State DONE:
  - rsp_valid=1 and stall=0, so the pipeline advances this cycle.
  - rsp_rdata = extended load data; 0 for stores.
  - req_valid is ignored (still the old request) → IDLE.
- State FAULT:
  - fault=1, fault_cause valid, stall=0 for exactly one cycle → IDLE.
- Latency with zero-wait memory: accept cycle, 1 BUSY cycle, DONE = 3 cycles, i.e. 2 stall cycles. Each wait state adds 1 cycle.
- Read path:
  - shift ddt_i right by 8*addr[LANE_W-1:0];
  - take the low 8/16/32/64 bits per size;
  - extend by bit 7/15/31 when signed, else zero-extend.
- Write path: byte data replicated on every byte lane, half on every half lane, word on every word lane.
- Reset in BUSY: MREQ and ddt_oe are 0 after the reset edge. A late ACKD_n is ignored in IDLE.
- ACKD_n low outside BUSY: ignored.
- Counter saturates; it cannot wrap.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - fault causes FC_MISALIGN/FC_TIMEOUT/FC_ILLSIZE;
  - state encoding IDLE/BUSY/DONE/FAULT.
- Sub-module dmem_lane_align is purely combinational: store-data replication and load extract/extend, parametrised by XLEN.
- The FSM, counter and bus registers stay in dmem_bus_ctrl.

Test Plan:
- Store, 2 wait states: sw addr 0x100, data 0xDEADBEEF; ACKD_n low on the 3rd BUSY cycle.
  - Expect MREQ=WRITE=ddt_oe=1 for 3 cycles, DAD=0x100, SIZE=10.
  - Expect stall high 4 cycles, then rsp_valid 1 cycle.
- Signed byte load, zero-wait: lb addr 0x103, ddt_i=0x80FF_FFFF, req_signed=1.
  - Expect rsp_rdata=0xFFFFFF80 and 2 stall cycles.
  - Repeat with req_signed=0 (lbu): expect rsp_rdata=0x00000080.
- Halfword store replication: sh addr 0x102, wdata 0x1234ABCD.
  - Expect ddt_o=0xABCDABCD, SIZE=01.
- Misaligned load: lw addr 0x101.
  - Expect fault=1 with cause 01, MREQ never asserted, stall high 1 cycle only.
- Timeout: TIMEOUT=4, ACKD_n held high.
  - Expect MREQ high exactly 4 cycles, then fault with cause 10; subsequent normal access completes.
- Reset mid-access: assert rst during the 2nd BUSY cycle.
  - Expect MREQ=0 and stall=0 after the edge, and no rsp_valid on a later ACKD_n pulse.
  - XLEN=32 ld (size 11): expect fault cause 11.
